// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, drives the imem request/ack
// handshake and feeds decode through an output register backed by a one-entry skid.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | first cycle after reset, no request yet
// REQ     | request outstanding at imem_addr (== pc)
// HOLD    | skid full, request dropped until decode drains the output
// DISCARD | redirected while a request was unacked; its data will be dropped
module pc_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  use_branch,
  input  logic [ADDR_WIDTH-1:0] branch_out,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_inst
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t                state_q,      state_d;
  logic [ADDR_WIDTH-1:0] pc_q,         pc_d;
  logic                  req_q,        req_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic                  if_valid_q,   if_valid_d;
  logic [ADDR_WIDTH-1:0] if_pc_q,      if_pc_d;
  logic [DATA_WIDTH-1:0] if_inst_q,    if_inst_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q,    skid_pc_d;
  logic [DATA_WIDTH-1:0] skid_inst_q,  skid_inst_d;

  logic                  consume;
  logic                  slot_free;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] target;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;

    consume   = if_valid_q && !stall;
    slot_free = !if_valid_q || !stall;
    pc_plus4  = pc_q + ADDR_WIDTH'(4);
    target    = branch_out & ~ADDR_WIDTH'(3);

    if (consume) begin
      if_valid_d = 1'b0;
    end

    if (use_branch) begin
      // Redirect wins over stall and any ack arriving in the same cycle.
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = target;
      case (state_q)
        REQ, DISCARD: begin
          if (imem_ack) begin
            req_d   = 1'b1;
            addr_d  = target;
            state_d = REQ;
          end else begin
            state_d = DISCARD;
          end
        end
        default: begin
          req_d   = 1'b1;
          addr_d  = target;
          state_d = REQ;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
        REQ: begin
          if (imem_ack) begin
            pc_d   = pc_plus4;
            addr_d = pc_plus4;
            if (slot_free) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_q;
              if_inst_d  = imem_data;
              req_d      = 1'b1;
            end else begin
              skid_valid_d = 1'b1;
              skid_pc_d    = pc_q;
              skid_inst_d  = imem_data;
              req_d        = 1'b0;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid_d   = skid_valid_q;
            if_pc_d      = skid_pc_q;
            if_inst_d    = skid_inst_q;
            skid_valid_d = 1'b0;
            req_d        = 1'b1;
            addr_d       = pc_q;
            state_d      = REQ;
          end
        end
        DISCARD: begin
          // pc already holds the redirect target; the stale response is dropped.
          if (imem_ack) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = REQ;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= PC_ADDR;
      req_q        <= 1'b0;
      addr_q       <= PC_ADDR;
      if_valid_q   <= 1'b0;
      if_pc_q      <= PC_ADDR;
      if_inst_q    <= NOP;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= PC_ADDR;
      skid_inst_q  <= NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: cycle-stepped memory responder plus an in-order
// scoreboard of expected (pc, inst) pairs pushed at each accepted ack.
module tb_pc_fetch;

  localparam logic [31:0] PC_ADDR = 32'h8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        use_branch;
  logic [31:0] branch_out;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  pc_fetch #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .PC_ADDR   (PC_ADDR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .use_branch(use_branch),
    .branch_out(branch_out),
    .stall     (stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst)
  );

  int          n_vec;
  int          n_miscomp;
  int          n_seen;
  int          n_acks;
  sb_t         sb[$];
  logic [31:0] exp_pc;
  bit          drop;
  logic [31:0] drop_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected run to finish earlier");
    $fatal(1, "watchdog");
  end

  // Instruction word differs from its address so pc/inst swaps are visible.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the model, clock, then score any new instruction.
  task automatic step(input bit ack_en, input bit stl, input bit br,
                      input logic [31:0] tgt, input bit rst);
    bit  prev_hold;
    sb_t e;
    reset      = rst;
    stall      = stl;
    use_branch = br;
    branch_out = tgt;
    imem_ack   = ack_en && imem_req && !rst;
    imem_data  = imem_ack ? mem_data(imem_addr) : 32'hDEAD_BEEF;
    prev_hold  = if_valid && stl;

    if (rst) begin
      sb.delete();
      exp_pc = PC_ADDR;
      drop   = 1'b0;
    end else begin
      if (imem_ack) begin
        n_acks++;
        if (drop) begin
          check_eq("discard_addr", imem_addr, drop_addr);
          drop = 1'b0;
        end else begin
          check_eq("fetch_addr", imem_addr, exp_pc);
          if (!br) begin
            sb.push_back('{pc: exp_pc, inst: mem_data(exp_pc)});
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
      if (br) begin
        sb.delete();
        if (imem_req && !imem_ack && !drop) begin
          drop      = 1'b1;
          drop_addr = exp_pc;
        end
        exp_pc = {tgt[31:2], 2'b00};
      end
    end

    @(posedge clk);
    #1;
    if (!rst && if_valid && !prev_hold) begin
      n_seen++;
      check_eq("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("if_pc", if_pc, e.pc);
        check_eq("if_inst", if_inst, e.inst);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_if_valid"}, if_valid, 0);
    check_eq({tag, "_if_pc"}, if_pc, PC_ADDR);
    check_eq({tag, "_if_inst"}, if_inst, NOP);
    check_eq({tag, "_imem_req"}, imem_req, 0);
    check_eq({tag, "_imem_addr"}, imem_addr, PC_ADDR);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    check_reset_state("reset");
  endtask

  initial begin
    int n0;
    int a0;
    n_vec      = 0;
    n_miscomp  = 0;
    n_seen     = 0;
    n_acks     = 0;
    drop       = 1'b0;
    drop_addr  = 32'h0;
    exp_pc     = PC_ADDR;
    reset      = 1'b1;
    use_branch = 1'b0;
    branch_out = 32'h0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_data  = 32'h0;

    // Reset values, then the IDLE cycle issues the boot request.
    do_reset();
    step(0, 0, 0, 32'h0, 0);
    check_eq("boot_req", imem_req, 1);
    check_eq("boot_addr", imem_addr, PC_ADDR);
    check_eq("boot_if_valid", if_valid, 0);
    check_eq("boot_if_inst", if_inst, NOP);

    // Zero-wait memory: one instruction per cycle.
    n0 = n_seen;
    repeat (8) step(1, 0, 0, 32'h0, 0);
    check_eq("zero_wait_rate", n_seen - n0, 8);

    // Stall 4 cycles with ack offered: one fetch lands in skid, then request drops.
    a0 = n_acks;
    repeat (4) step(1, 1, 0, 32'h0, 0);
    check_eq("stall_acks", n_acks - a0, 1);
    check_eq("stall_req_low", imem_req, 0);
    check_eq("stall_if_valid", if_valid, 1);
    n0 = n_seen;
    repeat (4) step(1, 0, 0, 32'h0, 0);
    check_eq("resume_rate", n_seen - n0, 4);

    // Redirect while request to 8000_0010 waits for its ack.
    do_reset();
    step(0, 0, 0, 32'h0, 0);
    repeat (4) step(1, 0, 0, 32'h0, 0);
    check_eq("pre_branch_addr", imem_addr, 32'h8000_0010);
    step(0, 0, 1, 32'h8000_0100, 0);
    for (int i = 0; i < 3; i++) begin
      check_eq("discard_addr_hold", imem_addr, 32'h8000_0010);
      check_eq("discard_req_hold", imem_req, 1);
      check_eq("discard_if_valid", if_valid, 0);
      if (i < 2) step(0, 0, 0, 32'h0, 0);
    end
    step(1, 0, 0, 32'h0, 0);
    check_eq("post_discard_addr", imem_addr, 32'h8000_0100);
    check_eq("post_discard_if_valid", if_valid, 0);
    repeat (3) step(1, 0, 0, 32'h0, 0);

    // Redirect coincident with ack and stall; target low bits ignored.
    step(1, 1, 1, 32'h8000_0203, 0);
    check_eq("br_ack_if_valid", if_valid, 0);
    check_eq("br_ack_addr", imem_addr, 32'h8000_0200);
    check_eq("br_ack_req", imem_req, 1);
    repeat (3) step(1, 0, 0, 32'h0, 0);

    // Address wrap at the top of the space.
    step(1, 0, 1, 32'hFFFF_FFF8, 0);
    repeat (2) step(1, 0, 0, 32'h0, 0);
    check_eq("wrap_addr", imem_addr, 32'h0000_0000);
    repeat (2) step(1, 0, 0, 32'h0, 0);

    // Reset with a request outstanding.
    step(0, 0, 0, 32'h0, 0);
    check_eq("pre_reset_req", imem_req, 1);
    step(0, 0, 0, 32'h0, 1);
    check_reset_state("mid_req_reset");
    step(0, 0, 0, 32'h0, 0);
    check_eq("restart_addr", imem_addr, PC_ADDR);
    repeat (2) step(1, 0, 0, 32'h0, 0);

    // Random ack/stall/redirect mix.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0), $urandom, 0);
    end
    repeat (6) step(0, 0, 0, 32'h0, 0);
    check_eq("drain_sb_empty", sb.size(), 0);
    check_eq("drain_if_valid", if_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
